// File: rtl/rv32im_pkg.sv
// Shared definitions for the RV32IM execute stage: ALU opcodes, M-extension
// funct3 codes and the sequencer state encoding.
package rv32im_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALU_RESP,
    ST_MD_RUN,
    ST_MD_FIX,
    ST_MD_DONE
  } seq_state_t;

  function automatic logic md_rs1_signed(input logic [2:0] funct3);
    return funct3 inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic md_rs2_signed(input logic [2:0] funct3);
    return funct3 inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/rv32im_muldiv_iter.sv
// Iterative radix-2 multiply/divide engine: operates on magnitudes in a
// double-width accumulator and applies sign correction in a final fix step.
module rv32im_muldiv_iter
  import rv32im_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned MD_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            step,
  input  logic            fix,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            count_zero,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(MD_CYCLES);

  logic [2:0]        op_q;
  logic              sign_a;
  logic              sign_b;
  logic              b_zero;
  logic [XLEN-1:0]   mag;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     cnt;

  logic              in_sign_a;
  logic              in_sign_b;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_partial;
  logic [XLEN+1:0]   div_trial;
  logic [2*XLEN-1:0] step_next;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fix_value;

  always_comb begin
    in_sign_a = md_rs1_signed(funct3) & op_a[XLEN-1];
    in_sign_b = md_rs2_signed(funct3) & op_b[XLEN-1];
    abs_a     = in_sign_a ? -op_a : op_a;
    abs_b     = in_sign_b ? -op_b : op_b;
  end

  // Mul keeps the multiplier in the low half and shifts the partial product in
  // from the top; div shifts the dividend out of the low half into the remainder.
  always_comb begin
    mul_sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag} : '0);
    div_partial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_trial   = {1'b0, div_partial} - {2'b00, mag};
    step_next   = '0;
    if (op_q[2]) begin
      if (!div_trial[XLEN+1])
        step_next = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
        step_next = {div_partial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      step_next = {mul_sum, acc[XLEN-1:1]};
    end
  end

  always_comb begin
    prod      = (sign_a ^ sign_b) ? -acc : acc;
    quo       = b_zero ? '1 : ((sign_a ^ sign_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0]);
    rem       = sign_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    fix_value = '0;
    case (op_q)
      MD_MUL:                     fix_value = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_value = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:            fix_value = quo;
      default:                    fix_value = rem;
    endcase
  end

  assign count_zero = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      b_zero <= 1'b0;
      mag    <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (abort) begin
      cnt    <= '0;
      result <= '0;
    end else if (start) begin
      op_q   <= funct3;
      sign_a <= in_sign_a;
      sign_b <= in_sign_b;
      b_zero <= (op_b == '0);
      cnt    <= CW'(MD_CYCLES - 1);
      if (funct3[2]) begin
        acc <= {{XLEN{1'b0}}, abs_a};
        mag <= abs_b;
      end else begin
        acc <= {{XLEN{1'b0}}, abs_b};
        mag <= abs_a;
      end
    end else if (step) begin
      acc <= step_next;
      if (cnt != '0)
        cnt <= cnt - CW'(1);
    end else if (fix) begin
      result <= fix_value;
    end
  end

endmodule

// File: rtl/rv32im_exec_sequencer.sv
// Execute-stage sequencer: steers issued ops to the external ALU or the
// iterative mul/div engine and merges both onto one writeback port.
module rv32im_exec_sequencer
  import rv32im_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned MD_CYCLES = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  logic            is_muldiv_i,
  input  logic [3:0]      operation_i,
  input  logic [XLEN-1:0] operand1_i,
  input  logic [XLEN-1:0] operand2_i,
  input  logic [4:0]      rd_i,
  output logic            alu_data_ready_o,
  output logic            alu_clear_o,
  output logic [3:0]      alu_operation_o,
  output logic [XLEN-1:0] alu_operand1_o,
  output logic [XLEN-1:0] alu_operand2_o,
  input  logic [XLEN-1:0] alu_result_i,
  output logic            result_valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o,
  output logic            busy_o,
  output logic            stall_o
);

  seq_state_t      state;
  logic [4:0]      rd_q;
  logic            valid_q;
  logic            accept;
  logic            count_zero;
  logic [XLEN-1:0] md_result;

  assign issue_ready_o    = state inside {ST_IDLE, ST_ALU_RESP, ST_MD_DONE};
  assign accept           = issue_valid_i & issue_ready_o & ~flush_i;
  assign stall_o          = issue_valid_i & ~issue_ready_o;
  assign busy_o           = state inside {ST_MD_RUN, ST_MD_FIX};

  assign alu_data_ready_o = accept & ~is_muldiv_i;
  assign alu_clear_o      = flush_i;
  assign alu_operation_o  = operation_i;
  assign alu_operand1_o   = operand1_i;
  assign alu_operand2_o   = operand2_i;

  assign result_valid_o   = valid_q;
  assign rd_o             = valid_q ? rd_q : '0;
  assign result_o         = !valid_q ? '0 :
                            (state == ST_ALU_RESP) ? alu_result_i : md_result;

  rv32im_muldiv_iter #(
    .XLEN      (XLEN),
    .MD_CYCLES (MD_CYCLES)
  ) u_muldiv (
    .clk        (clk_i),
    .rst_n      (rst_n_i),
    .start      (accept & is_muldiv_i),
    .abort      (flush_i),
    .step       (state == ST_MD_RUN),
    .fix        (state == ST_MD_FIX),
    .funct3     (operation_i[2:0]),
    .op_a       (operand1_i),
    .op_b       (operand2_i),
    .count_zero (count_zero),
    .result     (md_result)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= ST_IDLE;
      rd_q    <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      state   <= ST_IDLE;
      valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_ALU_RESP, ST_MD_DONE: begin
          if (issue_valid_i) begin
            rd_q <= rd_i;
            if (is_muldiv_i) begin
              state   <= ST_MD_RUN;
              valid_q <= 1'b0;
            end else begin
              state   <= ST_ALU_RESP;
              valid_q <= 1'b1;
            end
          end else begin
            state   <= ST_IDLE;
            valid_q <= 1'b0;
          end
        end
        ST_MD_RUN: begin
          valid_q <= 1'b0;
          if (count_zero)
            state <= ST_MD_FIX;
        end
        ST_MD_FIX: begin
          state   <= ST_MD_DONE;
          valid_q <= 1'b1;
        end
        default: begin
          state   <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32im_exec_sequencer.sv
// Scoreboard bench for rv32im_exec_sequencer with a small external ALU model
// and a reference mul/div function built on native 64-bit arithmetic.
module tb_rv32im_exec_sequencer;
  import rv32im_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        issue_valid = 1'b0;
  logic        is_muldiv = 1'b0;
  logic [3:0]  operation = '0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic [4:0]  rd = '0;

  logic        issue_ready, alu_data_ready, alu_clear, result_valid, busy, stall;
  logic [3:0]  alu_operation;
  logic [31:0] alu_operand1, alu_operand2, alu_result, result;
  logic [4:0]  rd_out;

  rv32im_exec_sequencer #(
    .XLEN      (32),
    .MD_CYCLES (32)
  ) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .flush_i          (flush),
    .issue_valid_i    (issue_valid),
    .issue_ready_o    (issue_ready),
    .is_muldiv_i      (is_muldiv),
    .operation_i      (operation),
    .operand1_i       (op1),
    .operand2_i       (op2),
    .rd_i             (rd),
    .alu_data_ready_o (alu_data_ready),
    .alu_clear_o      (alu_clear),
    .alu_operation_o  (alu_operation),
    .alu_operand1_o   (alu_operand1),
    .alu_operand2_o   (alu_operand2),
    .alu_result_i     (alu_result),
    .result_valid_o   (result_valid),
    .result_o         (result),
    .rd_o             (rd_out),
    .busy_o           (busy),
    .stall_o          (stall)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-cycle ALU: captures on data_ready, result valid the following cycle.
  logic [3:0]  alu_op_q = '0;
  logic [31:0] alu_a_q = '0;
  logic [31:0] alu_b_q = '0;
  always @(posedge clk) begin
    if (alu_data_ready) begin
      alu_op_q <= alu_operation;
      alu_a_q  <= alu_operand1;
      alu_b_q  <= alu_operand2;
    end
  end
  assign alu_result = (alu_op_q == OP_SUB) ? alu_a_q - alu_b_q : alu_a_q + alu_b_q;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int unsigned due;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] md_ref(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sx, sy, ux, uy;
    logic [63:0] p;
    sx = {{32{a[31]}}, a};
    sy = {{32{b[31]}}, b};
    ux = {32'b0, a};
    uy = {32'b0, b};
    case (f)
      MD_MUL:    begin p = sx * sy; return p[31:0];  end
      MD_MULH:   begin p = sx * sy; return p[63:32]; end
      MD_MULHSU: begin p = sx * uy; return p[63:32]; end
      MD_MULHU:  begin p = ux * uy; return p[63:32]; end
      MD_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      MD_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      MD_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (result_valid) begin
        if (sb.size() == 0) begin
          check_eq("spurious_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("result", result, e.res);
          check_eq("rd", {27'd0, rd_out}, {27'd0, e.rd});
          check_eq("latency", cyc, e.due);
        end
      end else begin
        check_eq("idle_result", result, 32'd0);
        if (sb.size() != 0 && sb[0].due <= cyc) begin
          check_eq("missing_valid", 32'd0, 32'd1);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic issue(input logic md, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] r, input logic [31:0] exp);
    exp_t e;
    is_muldiv = md; operation = op; op1 = a; op2 = b; rd = r; issue_valid = 1'b1;
    @(negedge clk);
    check_eq("issue_ready", {31'd0, issue_ready}, 32'd1);
    check_eq("stall_idle", {31'd0, stall}, 32'd0);
    check_eq("alu_data_ready", {31'd0, alu_data_ready}, {31'd0, ~md});
    check_eq("alu_operand1", alu_operand1, a);
    e.res = exp; e.rd = r; e.due = cyc + (md ? 34 : 1);
    sb.push_back(e);
    @(posedge clk); #1;
    issue_valid = 1'b0;
  endtask

  task automatic md_issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r);
    issue(1'b1, {1'b0, f}, a, b, r, md_ref(f, a, b));
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      check_eq("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", {31'd0, result_valid}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_result", result, 32'd0);
    check_eq("rst_rd", {27'd0, rd_out}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ALU back-to-back
    issue(1'b0, OP_ADD, 32'd5, 32'd7, 5'd3, 32'd12);
    issue(1'b0, OP_SUB, 32'd5, 32'd7, 5'd4, 32'hFFFF_FFFE);
    drain();

    // MULH with stall probing while the engine runs
    md_issue(MD_MULH, 32'hFFFF_FFFF, 32'd2, 5'd9);
    repeat (4) @(posedge clk);
    #1;
    is_muldiv = 1'b0; operation = OP_ADD; issue_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("stall_busy", {31'd0, stall}, 32'd1);
      check_eq("busy", {31'd0, busy}, 32'd1);
      check_eq("no_alu_dr", {31'd0, alu_data_ready}, 32'd0);
      @(posedge clk); #1;
    end
    issue_valid = 1'b0;
    drain();

    // MUL, then ADD issued in the cycle the mul result pulses
    md_issue(MD_MUL, 32'hFFFF_FFFF, 32'd2, 5'd10);
    repeat (33) @(posedge clk);
    #1;
    issue(1'b0, OP_ADD, 32'd1, 32'd1, 5'd5, 32'd2);
    drain();

    // Divide corner cases
    md_issue(MD_DIVU, 32'd100, 32'd0, 5'd11);            drain();
    md_issue(MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12); drain();
    md_issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13); drain();
    md_issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 5'd14);         drain();
    md_issue(MD_REM, 32'hFFFF_FFF9, 32'd2, 5'd15);         drain();
    md_issue(MD_DIV, 32'hFFFF_FFFB, 32'd0, 5'd16);         drain();
    md_issue(MD_REMU, 32'd7, 32'd0, 5'd17);                drain();
    md_issue(MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd18); drain();

    // Random mul/div mix
    for (int i = 0; i < 12; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i % 4 == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : $urandom_range(1, 300));
      md_issue(3'($urandom_range(0, 7)), a, b, 5'(i + 1));
      drain();
    end

    // Flush concurrent with an ALU result pulse: the pulse stands
    issue(1'b0, OP_ADD, 32'd20, 32'd22, 5'd6, 32'd42);
    flush = 1'b1;
    @(negedge clk);
    check_eq("flush_clear", {31'd0, alu_clear}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    drain();

    // Flush mid-divide
    md_issue(MD_DIV, 32'd1000, 32'd7, 5'd20);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check_eq("flush_clear_md", {31'd0, alu_clear}, 32'd1);
    check_eq("flush_busy_before", {31'd0, busy}, 32'd1);
    void'(sb.pop_back());
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check_eq("flush_busy_after", {31'd0, busy}, 32'd0);
    check_eq("flush_ready", {31'd0, issue_ready}, 32'd1);
    repeat (40) @(posedge clk);
    #1;
    issue(1'b0, OP_SUB, 32'd9, 32'd4, 5'd21, 32'd5);
    drain();

    // Async reset mid-run
    md_issue(MD_MUL, 32'd123, 32'd456, 5'd22);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", {31'd0, result_valid}, 32'd0);
    check_eq("arst_busy", {31'd0, busy}, 32'd0);
    check_eq("arst_result", result, 32'd0);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    md_issue(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd23);
    drain();
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
